alu_mc: RTL and testbench

//   Parametrised multi-cycle ALU; successor to the single-cycle 19-bit ALU.
//   - Operand width is configurable.
//   - Operations use an accept/done handshake.
//   - DIV/MOD run on an iterative restoring divider.
//   - Adds shift-by-imm and CMP.
//   - FLAG is a sticky-free, per-operation status word.

---
 rtl/alu_mc.sv | 183 ++++++++++++++++++
 tb/tb_alu_mc.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: parametrised multi-cycle ALU with accept/done handshake and iterative restoring divider
//   clk     rising-edge clock
//   reset   asynchronous active-high reset
//   aluen   request valid, accepted when aluen && ready at a clk edge
//   opcode  operation select
//   r2/r3   operands A/B, latched at accept
//   imm     shift amount for SHL/SHR
//   ready   high when idle and able to accept
//   r1      result register, holds its value between operations
//   FLAG    status of the last completed operation
//   done    one-cycle pulse when r1/FLAG update
module alu_mc #(
   parameter int WIDTH = 19,
   parameter int CNTW  = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             aluen,
   input  logic [5:0]       opcode,
   input  logic [WIDTH-1:0] r2,
   input  logic [WIDTH-1:0] r3,
   input  logic [2:0]       imm,
   output logic             ready,
   output logic [WIDTH-1:0] r1,
   output logic [7:0]       FLAG,
   output logic             done
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] DIV  = 1'b1;
   localparam logic [5:0] OP_ADD = 6'd1;
   localparam logic [5:0] OP_SUB = 6'd2;
   localparam logic [5:0] OP_MUL = 6'd3;
   localparam logic [5:0] OP_DIV = 6'd4;
   localparam logic [5:0] OP_MOD = 6'd5;
   localparam logic [5:0] OP_SHL = 6'd6;
   localparam logic [5:0] OP_AND = 6'd7;
   localparam logic [5:0] OP_OR  = 6'd8;
   localparam logic [5:0] OP_XOR = 6'd9;
   localparam logic [5:0] OP_SHR = 6'd10;
   localparam logic [5:0] OP_NOT = 6'd11;
   localparam logic [5:0] OP_CMP = 6'd12;
   logic [0:0]         state;
   logic               pend;
   logic [5:0]         op_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [2:0]         imm_q;
   logic [WIDTH-1:0]   dq, dv, rem;
   logic [CNTW-1:0]    cnt;
   logic               mod_q;
   logic               accept, div_start;
   logic [WIDTH:0]     sum, diff, sl, sr;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   res;
   logic               wr, c, v, dz, mo, ill;
   logic [7:0]         flg;
   logic [WIDTH:0]     sh, sub;
   logic               ge;
   logic [WIDTH-1:0]   rem_n, q_n, dres;
   assign ready     = (state == IDLE) && !reset;
   assign accept    = aluen && ready;
   assign div_start = accept && (opcode == OP_DIV || opcode == OP_MOD) && (r3 != '0);
   // single-cycle datapath works on operands latched at accept
   always_comb begin
      sum  = {1'b0, a_q} + {1'b0, b_q};
      diff = {1'b0, a_q} - {1'b0, b_q};
      prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
      // bit WIDTH of sl / bit 0 of sr catch the last bit shifted out (0 when imm == 0)
      sl   = {1'b0, a_q} << imm_q;
      sr   = {a_q, 1'b0} >> imm_q;
      res  = r1;
      wr   = 1'b1;
      c    = 1'b0;
      v    = 1'b0;
      dz   = 1'b0;
      mo   = 1'b0;
      ill  = 1'b0;
      case (op_q)
         OP_ADD: begin
            res = sum[WIDTH-1:0];
            c   = sum[WIDTH];
            v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SUB, OP_CMP: begin
            res = diff[WIDTH-1:0];
            wr  = (op_q == OP_SUB);
            c   = diff[WIDTH];
            v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_MUL: begin
            res = prod[WIDTH-1:0];
            mo  = |prod[2*WIDTH-1:WIDTH];
         end
         // only zero-divisor DIV/MOD take the single-cycle path
         OP_DIV: begin
            res = '1;
            dz  = 1'b1;
         end
         OP_MOD: begin
            res = a_q;
            dz  = 1'b1;
         end
         OP_SHL: begin
            res = sl[WIDTH-1:0];
            c   = sl[WIDTH];
         end
         OP_SHR: begin
            res = sr[WIDTH:1];
            c   = sr[0];
         end
         OP_AND: res = a_q & b_q;
         OP_OR:  res = a_q | b_q;
         OP_XOR: res = a_q ^ b_q;
         OP_NOT: res = ~a_q;
         default: begin
            wr  = 1'b0;
            ill = 1'b1;
         end
      endcase
      flg = ill ? 8'h40 : {2'b00, mo, dz, res[WIDTH-1], v, c, res == '0};
   end
   // one restoring step: shift in the next dividend bit, subtract if it fits
   always_comb begin
      sh    = {rem, dq[WIDTH-1]};
      sub   = sh - {1'b0, dv};
      ge    = !sub[WIDTH];
      rem_n = ge ? sub[WIDTH-1:0] : sh[WIDTH-1:0];
      q_n   = {dq[WIDTH-2:0], ge};
      dres  = mod_q ? rem_n : q_n;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         pend  <= 1'b0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         imm_q <= '0;
         dq    <= '0;
         dv    <= '0;
         rem   <= '0;
         cnt   <= '0;
         mod_q <= 1'b0;
         r1    <= '0;
         FLAG  <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         pend <= 1'b0;
         if (pend) begin
            if (wr) r1 <= res;
            FLAG <= flg;
            done <= 1'b1;
         end
         if (state == DIV) begin
            rem <= rem_n;
            dq  <= q_n;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
               r1    <= dres;
               FLAG  <= {4'b0000, dres[WIDTH-1], 2'b00, dres == '0};
               done  <= 1'b1;
               state <= IDLE;
            end
         end
         if (accept) begin
            if (div_start) begin
               state <= DIV;
               dq    <= r2;
               dv    <= r3;
               rem   <= '0;
               cnt   <= CNTW'(WIDTH - 1);
               mod_q <= (opcode == OP_MOD);
            end else begin
               pend  <= 1'b1;
               op_q  <= opcode;
               a_q   <= r2;
               b_q   <= r3;
               imm_q <= imm;
            end
         end
      end
   end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed table-driven bench for alu_mc at WIDTH=19
module tb_alu_mc;
   localparam int W = 19;
   typedef struct {
      logic [5:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2:0]   sh;
      logic [W-1:0] r1;
      logic [7:0]   flg;
      int           lat;
   } vec_t;
   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         aluen = 1'b0;
   logic [5:0]   opcode = '0;
   logic [W-1:0] r2 = '0;
   logic [W-1:0] r3 = '0;
   logic [2:0]   imm = '0;
   logic         ready;
   logic [W-1:0] r1;
   logic [7:0]   FLAG;
   logic         done;
   int checks = 0;
   int errors = 0;
   vec_t vt[23];
   alu_mc #(.WIDTH(W), .CNTW(5)) dut (
      .clk(clk), .reset(reset), .aluen(aluen), .opcode(opcode),
      .r2(r2), .r3(r3), .imm(imm), .ready(ready), .r1(r1), .FLAG(FLAG), .done(done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask
   task automatic issue(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s);
      @(negedge clk);
      aluen = 1'b1;
      opcode = op;
      r2 = a;
      r3 = b;
      imm = s;
      @(posedge clk);
      #1 aluen = 1'b0;
   endtask
   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask
   initial begin
      int lat, busy, dones, done_at;
      vt[0]  = '{6'd1,  19'd10,      19'd15,      3'd0, 19'd25,      8'h00, 1};
      vt[1]  = '{6'd2,  19'd5,       19'd20,      3'd0, 19'd524273,  8'h0A, 1};
      vt[2]  = '{6'd12, 19'd7,       19'd7,       3'd0, 19'd524273,  8'h01, 1};
      vt[3]  = '{6'd4,  19'd40,      19'd8,       3'd0, 19'd5,       8'h00, 19};
      vt[4]  = '{6'd5,  19'd40,      19'd7,       3'd0, 19'd5,       8'h00, 19};
      vt[5]  = '{6'd4,  19'd10,      19'd0,       3'd0, 19'h7FFFF,   8'h18, 1};
      vt[6]  = '{6'd5,  19'd10,      19'd0,       3'd0, 19'd10,      8'h10, 1};
      vt[7]  = '{6'd3,  19'd1024,    19'd1024,    3'd0, 19'd0,       8'h21, 1};
      vt[8]  = '{6'd6,  19'h40001,   19'd0,       3'd1, 19'd2,       8'h02, 1};
      vt[9]  = '{6'd7,  19'h0F0F0,   19'h0FF00,   3'd0, 19'h0F000,   8'h00, 1};
      vt[10] = '{6'd8,  19'h000F0,   19'h00F00,   3'd0, 19'h00FF0,   8'h00, 1};
      vt[11] = '{6'd9,  19'h05555,   19'h05555,   3'd0, 19'd0,       8'h01, 1};
      vt[12] = '{6'd10, 19'd5,       19'd0,       3'd1, 19'd2,       8'h02, 1};
      vt[13] = '{6'd11, 19'd0,       19'd0,       3'd0, 19'h7FFFF,   8'h08, 1};
      vt[14] = '{6'd1,  19'h3FFFF,   19'd1,       3'd0, 19'h40000,   8'h0C, 1};
      vt[15] = '{6'd1,  19'h7FFFF,   19'd1,       3'd0, 19'd0,       8'h03, 1};
      vt[16] = '{6'd6,  19'd7,       19'd0,       3'd0, 19'd7,       8'h00, 1};
      vt[17] = '{6'd0,  19'd123,     19'd45,      3'd0, 19'd7,       8'h40, 1};
      vt[18] = '{6'd2,  19'h40000,   19'd1,       3'd0, 19'h3FFFF,   8'h04, 1};
      vt[19] = '{6'd12, 19'd3,       19'd5,       3'd0, 19'h3FFFF,   8'h0A, 1};
      vt[20] = '{6'd4,  19'h7FFFF,   19'd3,       3'd0, 19'h2AAAA,   8'h00, 19};
      vt[21] = '{6'd3,  19'h7FFFF,   19'h7FFFF,   3'd0, 19'd1,       8'h20, 1};
      vt[22] = '{6'd10, 19'h40000,   19'd0,       3'd7, 19'h00800,   8'h00, 1};
      #12;
      chk("reset r1", 32'(r1), 32'd0);
      chk("reset FLAG", 32'(FLAG), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset ready", 32'(ready), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("ready after release", 32'(ready), 32'd1);
      for (int i = 0; i < 23; i++) begin
         issue(vt[i].op, vt[i].a, vt[i].b, vt[i].sh);
         wait_done(lat);
         chk($sformatf("v%0d latency", i), 32'(lat), 32'(vt[i].lat));
         chk($sformatf("v%0d r1", i), 32'(r1), 32'(vt[i].r1));
         chk($sformatf("v%0d FLAG", i), 32'(FLAG), 32'(vt[i].flg));
         #1 chk($sformatf("v%0d ready", i), 32'(ready), 32'd1);
      end
      issue(6'd4, 19'd40, 19'd8, 3'd0);
      busy = ready ? 0 : 1;
      dones = 0;
      done_at = -1;
      for (int i = 1; i <= 24; i++) begin
         @(negedge clk);
         if (i == 3) begin
            aluen = 1'b1;
            opcode = 6'd1;
            r2 = 19'd99;
            r3 = 19'd3;
         end
         if (i == 5) aluen = 1'b0;
         @(posedge clk);
         #1;
         if (!ready) busy++;
         if (done) begin
            dones++;
            done_at = i;
         end
      end
      chk("div busy cycles", 32'(busy), 32'd19);
      chk("div done count", 32'(dones), 32'd1);
      chk("div done edge", 32'(done_at), 32'd19);
      chk("div busy r1", 32'(r1), 32'd5);
      chk("div busy FLAG", 32'(FLAG), 32'd0);
      issue(6'd4, 19'd40, 19'd8, 3'd0);
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("abort r1", 32'(r1), 32'd0);
      chk("abort FLAG", 32'(FLAG), 32'd0);
      chk("abort done", 32'(done), 32'd0);
      chk("abort ready", 32'(ready), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      dones = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk);
         #1 if (done) dones++;
      end
      chk("abort no done", 32'(dones), 32'd0);
      chk("abort ready back", 32'(ready), 32'd1);
      issue(6'h3F, 19'd9, 19'd9, 3'd0);
      wait_done(lat);
      chk("ill latency", 32'(lat), 32'd1);
      chk("ill r1", 32'(r1), 32'd0);
      chk("ill FLAG", 32'(FLAG), 32'h40);
      @(posedge clk);
      #1 chk("ill done pulse", 32'(done), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
